// File: rtl/semafor_monitor.sv
// semafor_monitor: passive safety/timing checker for a pedestrian-crossing light controller
// Ports:
//   clk, rst_n            clock (posedge sampling), asynchronous active-low reset
//   buton                 pedestrian button, 1 = pressed
//   semafor_masini        car light, 1 = green
//   semafor_pietoni       pedestrian light, 1 = green
//   clr_err               synchronous clear of the sticky error flags
//   err_*                 sticky violation flags, err_any = OR of them
//   nr_cereri             served pedestrian requests, wraps
module semafor_monitor #(
  parameter int MIN_VERDE_MASINI  = 3,
  parameter int MIN_VERDE_PIETONI = 2,
  parameter int MIN_ROSU_COMUN    = 1,
  parameter int MAX_ASTEPTARE     = 6,
  parameter int CNT_W             = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             buton,
  input  logic             semafor_masini,
  input  logic             semafor_pietoni,
  input  logic             clr_err,
  output logic             err_conflict,
  output logic             err_clearance,
  output logic             err_min_masini,
  output logic             err_min_pietoni,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic             err_any,
  output logic [CNT_W-1:0] nr_cereri
);
  typedef enum logic [2:0] {INIT, PH_M, PH_R, PH_P, PH_C} phase_t;
  phase_t           phase_q, phase_d, ph, last_q, last_d;
  logic             first_q, first_d, cerere_q, cerere_d;
  logic             chg, chk, enter_p, idle, new_req, bad_gap;
  logic [CNT_W-1:0] dwell_q, dwell_d, wait_q, wait_d, nr_q, nr_d;
  // {conflict, clearance, min_masini, min_pietoni, timeout, spurious}
  logic [5:0]       err_q, err_d, err_new;
  always_comb begin
    ph      = semafor_masini ? (semafor_pietoni ? PH_C : PH_M) : (semafor_pietoni ? PH_P : PH_R);
    chg     = phase_q != ph;
    chk     = chg && phase_q != INIT;
    enter_p = chk && ph == PH_P;
    idle    = ph != PH_P;
    new_req = idle && !cerere_q && buton;
    phase_d = ph;
    dwell_d = chg ? CNT_W'(1) : (dwell_q == '1 ? dwell_q : dwell_q + 1'b1);
    last_d  = (ph == PH_M || ph == PH_P) ? ph : last_q;
    // the phase loaded right after reset was only partly observed, so its length is not judged
    first_d = phase_q == INIT ? 1'b1 : (chg ? 1'b0 : first_q);
    cerere_d = enter_p ? 1'b0 : (new_req ? 1'b1 : cerere_q);
    wait_d   = new_req ? '0 : ((idle && cerere_q && wait_q != '1) ? wait_q + 1'b1 : wait_q);
    nr_d     = nr_q + CNT_W'(enter_p && cerere_q);
    bad_gap  = phase_q == PH_R && dwell_q < CNT_W'(MIN_ROSU_COMUN) &&
               ((ph == PH_P && last_q == PH_M) || (ph == PH_M && last_q == PH_P));
    err_new[5] = ph == PH_C;
    err_new[4] = chk && ((phase_q == PH_M && ph == PH_P) || (phase_q == PH_P && ph == PH_M) || bad_gap);
    err_new[3] = chk && !first_q && phase_q == PH_M && dwell_q < CNT_W'(MIN_VERDE_MASINI);
    err_new[2] = chk && !first_q && phase_q == PH_P && dwell_q < CNT_W'(MIN_VERDE_PIETONI);
    // wait passes MAX-1 -> MAX exactly once per request, so this fires once
    err_new[1] = idle && cerere_q && wait_q == CNT_W'(MAX_ASTEPTARE - 1);
    err_new[0] = enter_p && !cerere_q;
    err_d      = (clr_err ? 6'b0 : err_q) | err_new;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INIT;
      last_q   <= INIT;
      first_q  <= 1'b0;
      dwell_q  <= '0;
      cerere_q <= 1'b0;
      wait_q   <= '0;
      nr_q     <= '0;
      err_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      last_q   <= last_d;
      first_q  <= first_d;
      dwell_q  <= dwell_d;
      cerere_q <= cerere_d;
      wait_q   <= wait_d;
      nr_q     <= nr_d;
      err_q    <= err_d;
    end
  end
  assign {err_conflict, err_clearance, err_min_masini, err_min_pietoni, err_timeout, err_spurious} = err_q;
  assign err_any   = |err_q;
  assign nr_cereri = nr_q;
endmodule
